// File: rtl/vga_rx_monitor.sv
// Receive-side VGA monitor: recovers pixel coordinates, checks line/frame geometry
// against RES_H x RES_V, accumulates a per-frame checksum and tracks lock state.
module vga_rx_monitor #(
  parameter int   RES_H        = 640,
  parameter int   RES_V        = 480,
  parameter logic HSYNC_ACTIVE = 1'b0,
  parameter logic VSYNC_ACTIVE = 1'b0
) (
  input  logic        clk_pixel,
  input  logic        arst,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        data_enable,
  input  logic [7:0]  vga_in,
  output logic [9:0]  pixel_x,
  output logic [9:0]  pixel_y,
  output logic [7:0]  pixel_data,
  output logic        pixel_valid,
  output logic        frame_done,
  output logic        frame_ok,
  output logic [15:0] frame_checksum,
  output logic        locked,
  output logic        err_line_len,
  output logic        err_frame,
  output logic        err_sync,
  output logic [7:0]  err_count
);

  typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;

  localparam logic [10:0] RES_H_W = 11'(RES_H);
  localparam logic [9:0]  RES_V_W = 10'(RES_V);

  function automatic logic [9:0] inc_sat10(input logic [9:0] v);
    return (v == 10'h3FF) ? v : v + 10'd1;
  endfunction

  function automatic logic [10:0] inc_sat11(input logic [10:0] v);
    return (v == 11'h7FF) ? v : v + 11'd1;
  endfunction

  function automatic logic [15:0] cksum_step(input logic [15:0] acc, input logic [7:0] pix);
    return {acc[14:0], acc[15]} ^ {8'h00, pix};
  endfunction

  function automatic logic [7:0] add_sat8(input logic [7:0] c, input logic [1:0] n);
    logic [8:0] s;
    s = {1'b0, c} + {7'b0, n};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  state_t      state_q, state_d;
  logic        hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d;
  logic [7:0]  vga_in_q, vga_in_d;
  logic        vsync_prev_q, vsync_prev_d, de_prev_q, de_prev_d;
  logic [9:0]  pixel_x_q, pixel_x_d, pixel_y_q, pixel_y_d;
  logic [10:0] run_cnt_q, run_cnt_d;
  logic [7:0]  pixel_data_q, pixel_data_d;
  logic        pixel_valid_q, pixel_valid_d;
  logic [15:0] acc_q, acc_d, frame_checksum_q, frame_checksum_d;
  logic        frame_done_q, frame_done_d, frame_ok_q, frame_ok_d;
  logic        err_line_len_q, err_line_len_d, err_frame_q, err_frame_d;
  logic        err_sync_q, err_sync_d, err_seen_q, err_seen_d;
  logic [7:0]  err_count_q, err_count_d;

  logic        hs_act, vs_act, vs_act_prev, vs_edge, de_rise, de_fall, active;
  logic [9:0]  lines_eff;
  logic [1:0]  err_n;

  always_comb begin
    hsync_d          = hsync;
    vsync_d          = vsync;
    de_d             = data_enable;
    vga_in_d         = vga_in;
    vsync_prev_d     = vsync_q;
    de_prev_d        = de_q;
    pixel_x_d        = pixel_x_q;
    run_cnt_d        = run_cnt_q;
    frame_ok_d       = frame_ok_q;
    frame_checksum_d = frame_checksum_q;
    state_d          = state_q;

    hs_act      = (hsync_q == HSYNC_ACTIVE);
    vs_act      = (vsync_q == VSYNC_ACTIVE);
    vs_act_prev = (vsync_prev_q == VSYNC_ACTIVE);
    vs_edge     = vs_act & ~vs_act_prev;
    de_rise     = de_q & ~de_prev_q;
    de_fall     = ~de_q & de_prev_q;
    active      = (state_q != SEARCH);

    pixel_valid_d = de_q & active;
    pixel_data_d  = vga_in_q;
    if (de_q) begin
      pixel_x_d = de_rise ? 10'd0 : inc_sat10(pixel_x_q);
      run_cnt_d = de_rise ? 11'd1 : inc_sat11(run_cnt_q);
    end

    // A line ending on the same cycle as the vsync edge still counts toward this frame.
    lines_eff = de_fall ? inc_sat10(pixel_y_q) : pixel_y_q;
    pixel_y_d = vs_edge ? 10'd0 : lines_eff;

    err_line_len_d = active & de_fall & (run_cnt_q != RES_H_W);
    err_sync_d     = active & de_q & (hs_act | vs_act);
    err_frame_d    = active & vs_edge & (lines_eff != RES_V_W);
    err_n          = {1'b0, err_line_len_d} + {1'b0, err_sync_d} + {1'b0, err_frame_d};
    err_count_d    = add_sat8(err_count_q, err_n);
    err_seen_d     = vs_edge ? 1'b0 : (err_seen_q | err_line_len_d | err_sync_d);

    acc_d = acc_q;
    if (vs_edge)            acc_d = 16'h0000;
    else if (pixel_valid_d) acc_d = cksum_step(acc_q, vga_in_q);

    frame_done_d = active & vs_edge;
    if (frame_done_d) begin
      frame_ok_d       = (lines_eff == RES_V_W) & ~err_seen_q & ~err_line_len_d & ~err_sync_d;
      frame_checksum_d = acc_q;
    end

    // Lock decisions follow the registered pulses, so they take effect one cycle later.
    case (state_q)
      SEARCH:  if (vs_edge) state_d = TRACK;
      TRACK:   if (frame_done_q & frame_ok_q) state_d = LOCKED;
      LOCKED:  if (err_line_len_q | err_sync_q | err_frame_q) state_d = TRACK;
      default: state_d = SEARCH;
    endcase
  end

  always_ff @(posedge clk_pixel) begin
    if (arst) begin
      state_q          <= SEARCH;
      hsync_q          <= 1'b0;
      vsync_q          <= 1'b0;
      de_q             <= 1'b0;
      vga_in_q         <= 8'h00;
      vsync_prev_q     <= 1'b0;
      de_prev_q        <= 1'b0;
      pixel_x_q        <= 10'd0;
      pixel_y_q        <= 10'd0;
      run_cnt_q        <= 11'd0;
      pixel_data_q     <= 8'h00;
      pixel_valid_q    <= 1'b0;
      acc_q            <= 16'h0000;
      frame_checksum_q <= 16'h0000;
      frame_done_q     <= 1'b0;
      frame_ok_q       <= 1'b0;
      err_line_len_q   <= 1'b0;
      err_frame_q      <= 1'b0;
      err_sync_q       <= 1'b0;
      err_seen_q       <= 1'b0;
      err_count_q      <= 8'h00;
    end else begin
      state_q          <= state_d;
      hsync_q          <= hsync_d;
      vsync_q          <= vsync_d;
      de_q             <= de_d;
      vga_in_q         <= vga_in_d;
      vsync_prev_q     <= vsync_prev_d;
      de_prev_q        <= de_prev_d;
      pixel_x_q        <= pixel_x_d;
      pixel_y_q        <= pixel_y_d;
      run_cnt_q        <= run_cnt_d;
      pixel_data_q     <= pixel_data_d;
      pixel_valid_q    <= pixel_valid_d;
      acc_q            <= acc_d;
      frame_checksum_q <= frame_checksum_d;
      frame_done_q     <= frame_done_d;
      frame_ok_q       <= frame_ok_d;
      err_line_len_q   <= err_line_len_d;
      err_frame_q      <= err_frame_d;
      err_sync_q       <= err_sync_d;
      err_seen_q       <= err_seen_d;
      err_count_q      <= err_count_d;
    end
  end

  assign pixel_x        = pixel_x_q;
  assign pixel_y        = pixel_y_q;
  assign pixel_data     = pixel_data_q;
  assign pixel_valid    = pixel_valid_q;
  assign frame_done     = frame_done_q;
  assign frame_ok       = frame_ok_q;
  assign frame_checksum = frame_checksum_q;
  assign locked         = (state_q == LOCKED);
  assign err_line_len   = err_line_len_q;
  assign err_frame      = err_frame_q;
  assign err_sync       = err_sync_q;
  assign err_count      = err_count_q;

endmodule

// File: tb/tb_vga_rx_monitor.sv
// Directed bench for vga_rx_monitor with an 8x4 geometry; expected values are hand-derived.
module tb_vga_rx_monitor;
  localparam int RH = 8;
  localparam int RV = 4;

  logic        clk_pixel = 1'b0;
  logic        arst, hsync, vsync, data_enable;
  logic [7:0]  vga_in;
  logic [9:0]  pixel_x, pixel_y;
  logic [7:0]  pixel_data;
  logic        pixel_valid, frame_done, frame_ok, locked;
  logic [15:0] frame_checksum;
  logic        err_line_len, err_frame, err_sync;
  logic [7:0]  err_count;

  always #5 clk_pixel = ~clk_pixel;

  vga_rx_monitor #(.RES_H(RH), .RES_V(RV), .HSYNC_ACTIVE(1'b0), .VSYNC_ACTIVE(1'b0)) dut (
    .clk_pixel(clk_pixel), .arst(arst), .hsync(hsync), .vsync(vsync),
    .data_enable(data_enable), .vga_in(vga_in), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .pixel_data(pixel_data), .pixel_valid(pixel_valid), .frame_done(frame_done),
    .frame_ok(frame_ok), .frame_checksum(frame_checksum), .locked(locked),
    .err_line_len(err_line_len), .err_frame(err_frame), .err_sync(err_sync),
    .err_count(err_count)
  );

  int checks = 0;
  int failures = 0;

  // Observation monitors: pixel count, raster order while enabled, pulse count.
  int vcnt = 0, seq_err = 0, pulse_cnt = 0, ex = 0, ey = 0;
  bit mon_en = 1'b0;
  always @(negedge clk_pixel) begin
    if (pixel_valid) vcnt <= vcnt + 1;
    if (err_line_len | err_sync | err_frame | frame_done) pulse_cnt <= pulse_cnt + 1;
    if (!mon_en) begin
      ex <= 0;
      ey <= 0;
    end else if (pixel_valid) begin
      if (pixel_x != 10'(ex) || pixel_y != 10'(ey)) seq_err <= seq_err + 1;
      if (ex == RH - 1) begin
        ex <= 0;
        ey <= ey + 1;
      end else begin
        ex <= ex + 1;
      end
    end
  end

  logic        c_fd, c_ok, c_ferr, c_lk, c_ell, b_ell, b_lk;
  logic [15:0] c_cs;
  logic [7:0]  c_ec, b_ec;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic hs, input logic vs, input logic de, input logic [7:0] pix);
    hsync = hs; vsync = vs; data_enable = de; vga_in = pix;
    @(posedge clk_pixel);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_px"}, pixel_x, 0);
    check({tag, "_py"}, pixel_y, 0);
    check({tag, "_pd"}, pixel_data, 0);
    check({tag, "_pv"}, pixel_valid, 0);
    check({tag, "_fd"}, frame_done, 0);
    check({tag, "_ok"}, frame_ok, 0);
    check({tag, "_cs"}, frame_checksum, 0);
    check({tag, "_lk"}, locked, 0);
    check({tag, "_ell"}, err_line_len, 0);
    check({tag, "_ef"}, err_frame, 0);
    check({tag, "_es"}, err_sync, 0);
    check({tag, "_ec"}, err_count, 0);
  endtask

  // Two vsync-active cycles then two idle; the frame_done cycle and the cycle after are sampled.
  task automatic vsync_pulse();
    cyc(1'b1, 1'b0, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, 1'b0, 8'h00);
    c_fd = frame_done; c_ok = frame_ok; c_cs = frame_checksum;
    c_ferr = err_frame; c_ec = err_count;
    cyc(1'b1, 1'b1, 1'b0, 8'h00);
    c_lk = locked;
    cyc(1'b1, 1'b1, 1'b0, 8'h00);
  endtask

  task automatic send_line(input int len, input logic [7:0] p0);
    for (int i = 0; i < len; i++) cyc(1'b1, 1'b1, 1'b1, (i == 0) ? p0 : 8'h00);
    cyc(1'b1, 1'b1, 1'b0, 8'h00);
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    c_ell = err_line_len; c_ec = err_count;
    cyc(1'b1, 1'b1, 1'b0, 8'h00);
    c_lk = locked;
  endtask

  task automatic send_frame(input int nl, input int bad_idx, input int bad_len, input logic [7:0] p00);
    for (int l = 0; l < nl; l++) begin
      send_line((l == bad_idx) ? bad_len : RH, (l == 0) ? p00 : 8'h00);
      if (l == bad_idx) begin
        b_ell = c_ell; b_lk = c_lk; b_ec = c_ec;
      end
    end
    cyc(1'b1, 1'b1, 1'b0, 8'h00);
    cyc(1'b1, 1'b1, 1'b0, 8'h00);
  endtask

  int vsnap, psnap;

  initial begin
    arst = 1'b1; hsync = 1'b1; vsync = 1'b1; data_enable = 1'b0; vga_in = 8'h00;
    cyc(1'b1, 1'b1, 1'b0, 8'h00);
    cyc(1'b1, 1'b1, 1'b0, 8'h00);
    check_zero("rst0");

    // Reset applied in the middle of a frame, then released mid-line.
    arst = 1'b0;
    send_line(RH, 8'h00);
    arst = 1'b1;
    cyc(1'b1, 1'b1, 1'b1, 8'h55);
    cyc(1'b1, 1'b1, 1'b1, 8'h55);
    check_zero("rst1");
    arst = 1'b0;
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b1, 8'h55);
    check("search_pv", pixel_valid, 0);
    cyc(1'b1, 1'b1, 1'b0, 8'h00);
    send_line(RH, 8'h00);
    vsync_pulse();
    check("search_fd", c_fd, 0);
    check("search_lk", c_lk, 0);

    // Clean frames: first close locks.
    send_frame(RV, -1, 0, 8'h00);
    vsync_pulse();
    check("f1_fd", c_fd, 1);
    check("f1_ok", c_ok, 1);
    check("f1_cs", c_cs, 16'h0000);
    check("f1_lk", c_lk, 1);
    send_frame(RV, -1, 0, 8'h00);
    vsync_pulse();
    check("f2_fd", c_fd, 1);
    check("f2_lk", c_lk, 1);

    // One 0xFF pixel at (0,0): 0x00FF rotated left 31 times gives 0x807F.
    vsnap = vcnt;
    mon_en = 1'b1;
    send_frame(RV, -1, 0, 8'hFF);
    mon_en = 1'b0;
    check("pix_vcnt", vcnt - vsnap, 32);
    check("pix_seq", seq_err, 0);
    vsync_pulse();
    check("pix_fd", c_fd, 1);
    check("pix_cs", c_cs, 16'h807F);
    check("pix_ok", c_ok, 1);
    check("pix_lk", c_lk, 1);

    // Short line on line 2.
    send_frame(RV, 2, 7, 8'h00);
    check("bl_ell", b_ell, 1);
    check("bl_lk", b_lk, 0);
    check("bl_ec", b_ec, 1);
    vsync_pulse();
    check("bl_fd", c_fd, 1);
    check("bl_ok", c_ok, 0);
    check("bl_ferr", c_ferr, 0);
    check("bl_lk", c_lk, 0);
    send_frame(RV, -1, 0, 8'h00);
    vsync_pulse();
    check("relock_ok", c_ok, 1);
    check("relock_lk", c_lk, 1);
    check("relock_ec", c_ec, 1);

    // Frame with only three lines.
    send_frame(RV - 1, -1, 0, 8'h00);
    vsync_pulse();
    check("sf_fd", c_fd, 1);
    check("sf_ferr", c_ferr, 1);
    check("sf_ok", c_ok, 0);
    check("sf_ec", c_ec, 2);
    check("sf_lk", c_lk, 0);

    // DE during hsync: sync error, then the one-cycle run is also a bad line.
    cyc(1'b0, 1'b1, 1'b1, 8'h12);
    cyc(1'b1, 1'b1, 1'b0, 8'h00);
    check("sync_es", err_sync, 1);
    check("sync_ec", err_count, 3);
    cyc(1'b1, 1'b1, 1'b0, 8'h00);
    check("sync_ell", err_line_len, 1);
    check("sync_ec2", err_count, 4);

    // Reset mid-line; remainder of frame must stay silent.
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b1, 8'hA5);
    arst = 1'b1;
    cyc(1'b1, 1'b1, 1'b1, 8'hA5);
    check_zero("rst2");
    arst = 1'b0;
    psnap = pulse_cnt;
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b1, 8'hA5);
    cyc(1'b1, 1'b1, 1'b0, 8'h00);
    send_line(RH, 8'h00);
    send_line(3, 8'h00);
    vsync_pulse();
    check("post_fd", c_fd, 0);
    check("post_pulses", pulse_cnt - psnap, 0);
    check("post_lk", c_lk, 0);

    // Now in TRACK: 300 bad lines saturate err_count.
    for (int i = 0; i < 200; i++) begin
      cyc(1'b1, 1'b1, 1'b1, 8'h00);
      cyc(1'b1, 1'b1, 1'b0, 8'h00);
    end
    cyc(1'b1, 1'b1, 1'b0, 8'h00);
    check("sat_ec200", err_count, 200);
    for (int i = 0; i < 100; i++) begin
      cyc(1'b1, 1'b1, 1'b1, 8'h00);
      cyc(1'b1, 1'b1, 1'b0, 8'h00);
    end
    cyc(1'b1, 1'b1, 1'b0, 8'h00);
    cyc(1'b1, 1'b1, 1'b0, 8'h00);
    check("sat_ec255", err_count, 255);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b0, 8'h00);
    check("sat_hold", err_count, 255);
    arst = 1'b1;
    cyc(1'b1, 1'b1, 1'b0, 8'h00);
    check("sat_clr", err_count, 0);
    arst = 1'b0;
    cyc(1'b1, 1'b1, 1'b0, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/vga_rx_monitor.md
Name: vga_rx_monitor

Overview:
- Receive-side counterpart of the VGA output path: consumes hsync, vsync, data_enable and the RRRGGGBB pixel bus, and recovers pixel_x and pixel_y per pixel.
- Checks line and frame geometry against RES_H x RES_V.
- Produces a per-frame pixel checksum.
- Used in the on-board self-test loopback and in simulation benches to verify the timing generator and sprite rendering.

Parameters:
- RES_H, 640, active pixels per line.
- RES_V, 480, active lines per frame.
- HSYNC_ACTIVE, 0, level of hsync while in sync pulse.
- VSYNC_ACTIVE, 0, level of vsync while in sync pulse.

Ports:
- clk_pixel  in  1  pixel clock; all inputs synchronous to it.
- arst  in  1  synchronous active-high reset.
- hsync  in  1  horizontal sync.
- vsync  in  1  vertical sync.
- data_enable  in  1  active-video qualifier.
- vga_in  in  8  pixel, RRRGGGBB.
- pixel_x  out  10  column of the pixel on pixel_data.
- pixel_y  out  10  row of the pixel on pixel_data.
- pixel_data  out  8  registered copy of vga_in.
- pixel_valid  out  1  pixel_x, pixel_y and pixel_data are valid.
- frame_done  out  1  one-cycle pulse at the vsync active edge, outside SEARCH.
- frame_ok  out  1  geometry of the frame just closed was correct; updates with frame_done.
- frame_checksum  out  16  checksum of the frame just closed; updates with frame_done.
- locked  out  1  high in LOCKED state.
- err_line_len  out  1  one-cycle pulse.
- err_frame  out  1  one-cycle pulse.
- err_sync  out  1  one-cycle pulse.
- err_count  out  8  saturating count of all error pulses.

Behaviour:
- Reset: while arst is high, every output is 0, all counters are 0, the checksum accumulator is 0, and state = SEARCH. Reset takes priority over all other events, including mid-line and mid-frame.
- Input stage: hsync, vsync, data_enable and vga_in are registered once (same clock domain, no synchronizer). Edge detection compares the registered value against a second registered copy.
  - vs_act = (vsync_q == VSYNC_ACTIVE).
  - hs_act = (hsync_q == HSYNC_ACTIVE).
- Pixel path, 2-cycle latency from input to output:
  - pixel_valid = de_q delayed one cycle; pixel_data = vga_in_q delayed one cycle.
  - pixel_x starts at 0 on the first DE cycle of a line and increments per DE cycle; it saturates at 1023.
  - pixel_y increments on each DE falling edge and clears at the vsync active edge; it saturates at 1023.
  - pixel_valid is forced to 0 in SEARCH.
- Checksum, applied per valid pixel: acc <= {acc[14:0],acc[15]} ^ {8'h00,pixel}.
- Line check: on each DE falling edge, if the DE run length != RES_H, pulse err_line_len.
- Sync check: pulse err_sync on any cycle where de_q is high and either hs_act or vs_act is high.
- Frame check, at the vsync active edge:
  - frame_ok = (line count == RES_V) and no error pulsed since the previous vsync edge.
  - Pulse err_frame if line count != RES_V.
  - frame_checksum <= acc; acc <= 0; line count <= 0.
- State machine:
  - SEARCH: wait for the vsync active edge, then go to TRACK. No frame_done on this edge, and no error checks in SEARCH.
  - TRACK: at the next vsync active edge, pulse frame_done. If frame_ok, go to LOCKED; otherwise stay in TRACK.
  - LOCKED: pulse frame_done at each vsync edge. Any err_* pulse moves to TRACK in the following cycle; locked falls on that cycle.
- err_count increments by the number of error pulses in a cycle (0-3) and saturates at 255. It clears only on arst.
- Simultaneous events: a DE falling edge coincident with the vsync active edge counts its line before the frame check.

Test Plan:
- RES_H=8, RES_V=4. Reset mid-frame, then 3 clean frames of all-zero pixels -> first vsync edge gives no frame_done; second edge gives frame_done, frame_ok=1, checksum 0x0000, locked=1 the next cycle.
- Locked, frame with pixel (0,0)=0xFF and all others 0x00 -> frame_checksum=0x807F, frame_ok=1; pixel_valid is high for exactly 32 cycles with x,y sequencing 0..7, 0..3.
- Locked, line 2 has 7 DE cycles -> err_line_len pulse at its DE fall, locked=0 the next cycle, err_count=1, frame_ok=0 at the vsync edge; the next clean frame relocks.
- Locked, frame with only 3 lines -> err_frame pulse and frame_ok=0 at the vsync edge, locked drops, err_count increments by 1.
- DE high for 1 cycle while hsync is active -> err_sync pulse. Then arst is asserted mid-line: all outputs go to 0, state returns to SEARCH, and the remainder of the frame produces no pulses.
- 300 consecutive bad lines -> err_count stops at 255 and holds until arst.
